load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32, as the data and address width (only 32 is supported).
REQ-002 SHALL take parameter MEM_DEPTH, default 256, as the data_mem depth in words.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cs_mem_read  in  1  load request from the core.
REQ-006 cs_mem_write  in  1  store request from the core.
REQ-007 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  in  32  byte address.
REQ-009 write_data  in  32  store data, right-aligned.
REQ-010 busy  out  1  high while a request is in progress; new requests are ignored while busy.
REQ-011 load_data  out  32  extended load result.
REQ-012 load_valid  out  1  one-cycle strobe; load_data is valid.
REQ-013 access_fault  out  1  one-cycle strobe for a rejected request.
REQ-014 mem_write  out  1  to data_mem cs_mem_write.
REQ-015 mem_addr  out  32  word index to data_mem, equal to {2'b00, addr[31:2]}.
REQ-016 mem_write_data  out  32  to data_mem write_data.
REQ-017 mem_read_data  in  32  from data_mem read_data; valid one edge after mem_addr is sampled.

Function
REQ-018 The unit SHALL have four states: IDLE, LD_WAIT, ST_READ and ST_MERGE. Every memory output SHALL be registered.
REQ-019 In IDLE, a request (read or write high) SHALL be accepted at rising edge E0. busy SHALL be high after E0 and stay high until the request retires.
REQ-020 If cs_mem_read and cs_mem_write are both high, the unit SHALL treat the request as a store and ignore the read.
REQ-021 Load: E0 SHALL register mem_addr and go to LD_WAIT. At E1 data_mem samples the address. At E2 the unit SHALL capture mem_read_data, select the lane and extend it, drive load_valid high for one cycle and return to IDLE.
REQ-022 Load lane selection SHALL use addr[1:0] for bytes and addr[1] for halves. B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-023 SW: E0 SHALL set mem_write=1, mem_addr and mem_write_data=write_data. data_mem writes at E1. After E1, mem_write=0, busy=0 and the state is IDLE.
REQ-024 SB/SH (read-modify-write): E0 SHALL go to ST_READ with mem_addr set. At E1 data_mem reads the word. At E2 the unit SHALL merge the low byte/half of write_data into the addressed lane of mem_read_data, set mem_write=1 and go to ST_MERGE. data_mem writes at E3. After E3 the state is IDLE.
REQ-025 load_data SHALL hold its last value until the next load_valid.
REQ-026 funct3 values 011, 110 and 111, and 100/101 on a store, SHALL cause no memory access. access_fault SHALL be high for one cycle after E0, busy SHALL stay low and the state SHALL stay IDLE.
REQ-027 Addresses whose word index is at or above MEM_DEPTH SHALL be passed through unchanged; data_mem handles them.
REQ-028 mem_write SHALL never be high for more than one consecutive cycle per request.

Reset
REQ-029 rst SHALL immediately force: state IDLE, busy=0, mem_write=0, mem_addr=0, mem_write_data=0, load_data=0, load_valid=0, access_fault=0.
REQ-030 Reset during ST_READ or ST_MERGE SHALL abort the request, with no write issued after reset asserts.
REQ-031 The first request SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-032 With LSU_MISALIGN_CHK_EN defined, halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL be rejected as in REQ-026.
REQ-033 Without LSU_MISALIGN_CHK_EN, low address bits SHALL be forced to alignment (addr[0]=0 for H, addr[1:0]=0 for W) and the access SHALL proceed.

Verification
REQ-034 SW addr 0x10, data 0xDEADBEEF -> mem_write=1 for one cycle with mem_addr=4; busy low 2 cycles after request.
REQ-035 Word 4 = 0xDEADBEEF; LB addr 0x13 -> load_valid 2 cycles after accept with load_data=0xFFFFFFDE; LBU -> 0x000000DE.
REQ-036 Word 4 = 0xDEADBEEF; SH addr 0x12, data 0x1234 -> single write of 0x1234BEEF to mem_addr=4 after E2; LW addr 0x10 then returns 0x1234BEEF.
REQ-037 funct3=111 load -> access_fault one cycle, no mem_write, busy never high; with the macro defined, LW addr 0x11 -> access_fault, and without it, LW addr 0x11 -> reads word 4.
REQ-038 SB in progress, rst pulsed in ST_MERGE -> mem_write falls immediately, memory word unchanged, state IDLE, all outputs 0.
REQ-039 Both read and write high, SW addr 0x20 -> store performed, no load_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a synchronous-read data_mem; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_CHK_EN rejects misaligned halfword/word accesses instead of aligning them.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_mem_read,
    input  logic                  cs_mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  access_fault,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int unsigned W = DATA_WIDTH;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LD_WAIT  = 2'd1;
    localparam logic [1:0] S_ST_READ  = 2'd2;
    localparam logic [1:0] S_ST_MERGE = 2'd3;

    generate
        if (DATA_WIDTH != 32 || MEM_DEPTH == 0) begin : g_bad_param
            $error("load_store_unit: only DATA_WIDTH=32 and MEM_DEPTH>0 are supported");
        end
    endgenerate

    logic [1:0]   state, state_nxt;
    logic         phase, phase_nxt;
    logic         busy_nxt, mem_write_nxt, load_valid_nxt, access_fault_nxt;
    logic [W-1:0] mem_addr_nxt, mem_write_data_nxt, load_data_nxt;
    logic [2:0]   op_f3, op_f3_nxt;
    logic [1:0]   op_lane, op_lane_nxt;
    logic [15:0]  op_wdata, op_wdata_nxt;

    logic         is_req, bad_f3, misalign, reject;
    logic [1:0]   lane;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;
    logic [W-1:0] load_ext, merged;

    // Request decode: legality and the aligned byte lane of the access
    always_comb begin
        is_req = cs_mem_read | cs_mem_write;
        bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (cs_mem_write && funct3[2]);
`ifdef LSU_MISALIGN_CHK_EN
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        reject = bad_f3 | misalign;
        case (funct3[1:0])
            2'b01:   lane = {addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = addr[1:0];
        endcase
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        rd_byte = mem_read_data[{op_lane, 3'b000} +: 8];
        rd_half = mem_read_data[{op_lane[1], 4'b0000} +: 16];
        case (op_f3)
            3'b000:  load_ext = {{(W-8){rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{(W-16){rd_half[15]}}, rd_half};
            3'b100:  load_ext = {{(W-8){1'b0}}, rd_byte};
            3'b101:  load_ext = {{(W-16){1'b0}}, rd_half};
            default: load_ext = mem_read_data;
        endcase
        merged = mem_read_data;
        if (op_f3[0]) begin
            merged[{op_lane[1], 4'b0000} +: 16] = op_wdata;
        end else begin
            merged[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt          = state;
        phase_nxt          = phase;
        busy_nxt           = busy;
        mem_write_nxt      = 1'b0;
        load_valid_nxt     = 1'b0;
        access_fault_nxt   = 1'b0;
        mem_addr_nxt       = mem_addr;
        mem_write_data_nxt = mem_write_data;
        load_data_nxt      = load_data;
        op_f3_nxt          = op_f3;
        op_lane_nxt        = op_lane;
        op_wdata_nxt       = op_wdata;

        case (state)
            S_IDLE: begin
                if (is_req) begin
                    if (reject) begin
                        access_fault_nxt = 1'b1;
                    end else begin
                        mem_addr_nxt = {2'b00, addr[W-1:2]};
                        op_f3_nxt    = funct3;
                        op_lane_nxt  = lane;
                        op_wdata_nxt = write_data[15:0];
                        busy_nxt     = 1'b1;
                        phase_nxt    = 1'b0;
                        if (!cs_mem_write) begin
                            state_nxt = S_LD_WAIT;
                        end else if (funct3 == 3'b010) begin
                            mem_write_nxt      = 1'b1;
                            mem_write_data_nxt = write_data;
                            state_nxt          = S_ST_MERGE;
                        end else begin
                            state_nxt = S_ST_READ;
                        end
                    end
                end
            end
            S_LD_WAIT: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    load_data_nxt  = load_ext;
                    load_valid_nxt = 1'b1;
                    busy_nxt       = 1'b0;
                    state_nxt      = S_IDLE;
                end
            end
            S_ST_READ: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    mem_write_data_nxt = merged;
                    mem_write_nxt      = 1'b1;
                    state_nxt          = S_ST_MERGE;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            phase          <= 1'b0;
            busy           <= 1'b0;
            mem_write      <= 1'b0;
            load_valid     <= 1'b0;
            access_fault   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            load_data      <= '0;
            op_f3          <= 3'b000;
            op_lane        <= 2'b00;
            op_wdata       <= 16'h0000;
        end else begin
            state          <= state_nxt;
            phase          <= phase_nxt;
            busy           <= busy_nxt;
            mem_write      <= mem_write_nxt;
            load_valid     <= load_valid_nxt;
            access_fault   <= access_fault_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_write_data <= mem_write_data_nxt;
            load_data      <= load_data_nxt;
            op_f3          <= op_f3_nxt;
            op_lane        <= op_lane_nxt;
            op_wdata       <= op_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level memory/timing model.
module tb_load_store_unit;

    localparam int unsigned DEPTH = 256;
`ifdef LSU_MISALIGN_CHK_EN
    localparam bit MIS_CHK = 1'b1;
`else
    localparam bit MIS_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_mem_read = 1'b0;
    logic        cs_mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        busy, load_valid, access_fault, mem_write;
    logic [31:0] load_data, mem_addr, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cs_mem_read(cs_mem_read), .cs_mem_write(cs_mem_write),
        .funct3(funct3), .addr(addr), .write_data(write_data), .busy(busy),
        .load_data(load_data), .load_valid(load_valid), .access_fault(access_fault),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    logic [31:0] tb_mem    [DEPTH];
    logic [31:0] model_mem [DEPTH];

    // Synchronous-read data memory; out-of-range words read as zero and ignore writes
    always @(posedge clk) begin
        if (mem_write && mem_addr < DEPTH) tb_mem[mem_addr[7:0]] <= mem_write_data;
        mem_read_data <= (mem_addr < DEPTH) ? tb_mem[mem_addr[7:0]] : 32'h0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    bit          cmp_en = 1'b0;
    logic        exp_busy = 0, exp_mw = 0, exp_valid = 0, exp_fault = 0, exp_ma_chk = 0;
    logic [31:0] exp_ld = 0, exp_ma = 0, exp_wd = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mem_write", 32'(mem_write), 32'(exp_mw));
            chk("load_valid", 32'(load_valid), 32'(exp_valid));
            chk("access_fault", 32'(access_fault), 32'(exp_fault));
            chk("load_data", load_data, exp_ld);
            if (exp_ma_chk) chk("mem_addr", mem_addr, exp_ma);
            if (exp_mw) chk("mem_write_data", mem_write_data, exp_wd);
        end
    end

    function automatic int aligned_off(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return int'(lo) & 2;
            2'b10:   return 0;
            default: return int'(lo);
        endcase
    endfunction

    function automatic bit is_bad(input bit st, input logic [2:0] f3, input logic [1:0] lo);
        bit b, mis;
        b   = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4);
        mis = ((f3 == 1 || f3 == 5) && lo[0]) || (f3 == 2 && lo != 2'b00);
        return b | (MIS_CHK && mis);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] widx,
                                               input logic [1:0] lo);
        logic [31:0] w;
        logic [7:0]  b8;
        logic [15:0] h16;
        int off, sv;
        w   = (widx < DEPTH) ? model_mem[widx[7:0]] : 32'h0;
        off = aligned_off(f3, lo);
        b8  = 8'(w >> (8 * off));
        h16 = 16'(w >> (8 * off));
        case (f3)
            3'd0: begin sv = int'($signed(b8));  return 32'(sv); end
            3'd1: begin sv = int'($signed(h16)); return 32'(sv); end
            3'd4: return {24'h0, b8};
            3'd5: return {16'h0, h16};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] m, v;
        int off;
        off = aligned_off(f3, lo);
        if (f3 == 1) begin
            m = 32'hFFFF << (8 * off);
            v = (wd & 32'hFFFF) << (8 * off);
        end else begin
            m = 32'hFF << (8 * off);
            v = (wd & 32'hFF) << (8 * off);
        end
        return (w & ~m) | v;
    endfunction

    task automatic set_idle_exp();
        exp_busy = 0; exp_mw = 0; exp_valid = 0; exp_fault = 0; exp_ma_chk = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            set_idle_exp();
        end
    endtask

    // Applies one request and sets the expected per-cycle outputs until it retires
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit garbage);
        int kind, n;
        logic [31:0] widx, ldv, nw, old;
        widx = a >> 2;
        if (is_bad(wr, f3, a[1:0])) kind = 0;
        else if (!wr)               kind = 1;
        else if (f3 == 3'd2)        kind = 2;
        else                        kind = 3;
        n   = (kind == 0) ? 1 : (kind == 1) ? 3 : (kind == 2) ? 2 : 4;
        ldv = model_load(f3, widx, a[1:0]);
        old = (widx < DEPTH) ? model_mem[widx[7:0]] : 32'h0;
        nw  = (kind == 2) ? wd : model_merge(old, f3, a[1:0], wd);
        if ((kind == 2 || kind == 3) && widx < DEPTH) model_mem[widx[7:0]] = nw;

        cs_mem_read = rd; cs_mem_write = wr; funct3 = f3; addr = a; write_data = wd;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (garbage && i < n - 1) begin
                cs_mem_read  = 1'($urandom);
                cs_mem_write = 1'($urandom);
                funct3       = 3'($urandom);
                addr         = $urandom;
                write_data   = $urandom;
            end else begin
                cs_mem_read = 0; cs_mem_write = 0; funct3 = 0; addr = 0; write_data = 0;
            end
            exp_busy   = (kind != 0) && (i < n - 1);
            exp_mw     = (kind == 2 && i == 0) || (kind == 3 && i == 2);
            exp_valid  = (kind == 1 && i == 2);
            exp_fault  = (kind == 0 && i == 0);
            if (exp_valid) exp_ld = ldv;
            exp_ma_chk = exp_mw || (kind == 1 && i == 0);
            exp_ma     = widx;
            exp_wd     = nw;
        end
    endtask

    initial begin
        logic [31:0] v, a;
        logic        rd, wr;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            tb_mem[i] = v;
            model_mem[i] = v;
        end

        #2;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_access_fault", 32'(access_fault), 32'h0);

        @(posedge clk); #1;
        rst = 0;
        set_idle_exp();
        exp_ld = 0;
        cmp_en = 1;

        do_req(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        chk("sw_word4", tb_mem[4], 32'hDEADBEEF);
        do_req(1, 0, 3'd0, 32'h13, 32'h0, 0);
        chk("lb_0x13", load_data, 32'hFFFFFFDE);
        do_req(1, 0, 3'd4, 32'h13, 32'h0, 0);
        chk("lbu_0x13", load_data, 32'h000000DE);
        do_req(0, 1, 3'd1, 32'h12, 32'h1234, 0);
        chk("sh_word4", tb_mem[4], 32'h1234BEEF);
        do_req(1, 0, 3'd2, 32'h10, 32'h0, 0);
        chk("lw_word4", load_data, 32'h1234BEEF);
        do_req(1, 0, 3'd7, 32'h10, 32'h0, 0);
        chk("f3_111_fault", 32'(access_fault), 32'h1);
        idle(1);
        do_req(1, 0, 3'd2, 32'h11, 32'h0, 0);
        if (MIS_CHK) chk("lw_0x11_fault", 32'(access_fault), 32'h1);
        else         chk("lw_0x11_data", load_data, 32'h1234BEEF);
        idle(1);
        do_req(1, 1, 3'd2, 32'h20, 32'hCAFEF00D, 0);
        chk("rd_wr_store", tb_mem[8], 32'hCAFEF00D);
        do_req(1, 0, 3'd2, 32'h1000, 32'h0, 0);
        idle(2);

        // Reset while a sub-word store is about to write
        cmp_en = 0;
        cs_mem_write = 1; funct3 = 3'd0; addr = 32'h25; write_data = 32'hAB;
        @(posedge clk); #1;
        cs_mem_write = 0; addr = 0; write_data = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rmw_mw_pre_rst", 32'(mem_write), 32'h1);
        rst = 1; #1;
        chk("rst_mid_mw", 32'(mem_write), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_wdata", mem_write_data, 32'h0);
        chk("rst_mid_ld", load_data, 32'h0);
        chk("rst_mid_valid", 32'(load_valid), 32'h0);
        chk("rst_mid_fault", 32'(access_fault), 32'h0);
        @(posedge clk); #1;
        chk("rst_word9_kept", tb_mem[9], model_mem[9]);
        rst = 0;
        exp_ld = 0;
        set_idle_exp();
        cmp_en = 1;

        for (int t = 0; t < 300; t++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            a  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 127));
            if (rd || wr) do_req(rd, wr, 3'($urandom), a, $urandom, 1'($urandom));
            else          idle(1);
            idle($urandom_range(0, 2));
        end
        idle(2);
        cmp_en = 0;

        for (int i = 0; i < DEPTH; i++) chk("final_mem", tb_mem[i], model_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
